image_kernel_window: RTL and testbench
======================================

# image_kernel_window

Streaming 5x5 window generator that sits directly upstream of the Prewitt gradient stage. It accepts a raster-order pixel stream, buffers KERNEL_SIZE-1 image lines, and presents a full KERNEL_SIZE x KERNEL_SIZE neighbourhood plus valid and start-of-frame flags. Its outputs connect straight to the gradient stage's kernel-buffer, valid and SOF inputs. Only interior windows are emitted; there is no border padding.

## Interface
- DATA_WIDTH, 8, pixel width in bits
- KERNEL_SIZE, 5, window edge length; must be odd and at least 3
- IMG_WIDTH, 640, pixels per line; must be at least KERNEL_SIZE
- IMG_HEIGHT, 480, lines per frame; must be at least KERNEL_SIZE
- i_clk  in  1  clock
- i_aresetn  in  1  reset, asynchronous, active-low
- i_pixel  in  DATA_WIDTH  unsigned pixel, raster order
- i_data_valid  in  1  pixel qualifier; one pixel accepted per cycle it is high
- i_start_of_frame  in  1  marks pixel (0,0); only meaningful when i_data_valid is high
- o_image_kernel_buffer  out  DATA_WIDTH x [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1]  window, indexed [row][col]; [0][0] is the top-left (oldest line, oldest column)
- o_data_valid  out  1  window qualifier, one-cycle pulse per emitted window
- o_start_of_frame  out  1  high together with the first emitted window of a frame

## Operation
- **Storage:** KERNEL_SIZE-1 line buffers, each IMG_WIDTH deep, addressed by the column counter. Line buffer k holds line (row-1-k) of the current frame. Register array or RAM is allowed; observable timing must not change.
- **Counters:** col in 0..IMG_WIDTH-1 and row in 0..IMG_HEIGHT-1, each $clog2 wide.
- **Accepted pixel:** any cycle with i_data_valid=1 and state ACTIVE, or with i_data_valid=1 and i_start_of_frame=1 in either state.
- **On each accepted pixel:**
  - Every window row shifts left one column: win[r][c] <= win[r][c+1].
  - The new right column is loaded: win[K-1][K-1] <= i_pixel; win[K-2-k][K-1] <= line buffer k at address col.
  - Line buffer 0 at address col is written with i_pixel. Line buffer k+1 at address col is written with line buffer k's old value (a cascade).
  - col increments. On wrap, col returns to 0 and row increments.
- **States:**
  - WAIT_SOF (the reset state): pixels without SOF are ignored entirely; the window, line buffers and counters are unchanged.
  - On valid+SOF from either state: go to ACTIVE, treat that pixel as (0,0), and set the counters so the next pixel is (0,1).
  - ACTIVE: after accepting pixel (IMG_HEIGHT-1, IMG_WIDTH-1), go to WAIT_SOF.
  - SOF while ACTIVE: the current frame is abandoned and restarts at (0,0). Stale line-buffer data is never emitted, because emission is gated by the counters.
- **Emission:** a window is emitted for the accepted pixel at (row, col) iff row >= K-1 and col >= K-1. The window is centred on pixel (row-(K-1)/2, col-(K-1)/2). This gives (IMG_HEIGHT-K+1)*(IMG_WIDTH-K+1) windows per frame.
- **SOF flag:** o_start_of_frame is high only on the window emitted for pixel (K-1, K-1).
- **Arithmetic:** pixels are passed unmodified; there is no arithmetic on pixel data.

## Timing
- **Reset values:** o_image_kernel_buffer all zero, o_data_valid=0, o_start_of_frame=0, state WAIT_SOF, row=col=0. Line buffer contents after reset are don't-care.
- **Latency:** 1 cycle. The window, o_data_valid and o_start_of_frame are registered and update on the edge after the accepted pixel's cycle.
- **Idle cycles:** o_data_valid is low in the cycle after any non-accepted cycle, and o_start_of_frame is low whenever o_data_valid is low.
- **Window hold:** o_image_kernel_buffer holds its value while no pixel is accepted. It changes on every accepted pixel, including non-emitted ones.
- **Flow control:** there is no backpressure. Back-to-back pixels give one window per cycle in the interior.
- **Bubbles:** gaps in i_data_valid anywhere, including mid-line, do not alter the window contents or the emission count.
- **Reset mid-frame:** all outputs clear immediately (asynchronously). The block then ignores pixels until the next SOF.

## Test plan
- **Full frame:** IMG_WIDTH=8, IMG_HEIGHT=6, K=5, pixel=row*16+col, continuous valid with SOF on the first pixel -> exactly 8 windows. First window [r][c]=r*16+c with o_start_of_frame=1, one cycle after pixel (4,4). Last window [r][c]=(r+1)*16+(c+3). Windows 2..8 have SOF=0.
- **Random bubbles:** same frame with i_data_valid randomly low 50% of cycles -> identical sequence of 8 windows. o_data_valid is never high in the cycle after an idle cycle.
- **No SOF:** 20 pixels before any SOF, then a full frame -> the 20 pixels have no effect; output matches the full-frame scenario. 10 extra pixels after the frame without SOF -> no windows.
- **SOF mid-frame:** after 30 pixels of a frame, SOF and a fresh full frame -> exactly 8 windows, identical to the full-frame scenario, with no window built from the abandoned pixels.
- **Reset mid-frame:** i_aresetn low while the window is non-zero -> all outputs read 0 in the same cycle. Pixels are ignored until SOF, and the next frame matches the full-frame scenario.
- **Back-to-back frames:** two consecutive frames, the second with pixel = 255 - (row*16+col) -> 16 windows, SOF on the 1st and 9th. The 9th window [r][c]=255-(r*16+c).

Source files
------------

// File: rtl/image_kernel_window.sv
// Streaming KERNEL_SIZE x KERNEL_SIZE window generator for raster-order pixels.
// Buffers KERNEL_SIZE-1 lines and emits only interior windows, one cycle after the pixel.
module image_kernel_window #(
    parameter int DATA_WIDTH  = 8,
    parameter int KERNEL_SIZE = 5,
    parameter int IMG_WIDTH   = 640,
    parameter int IMG_HEIGHT  = 480
) (
    input  logic                  i_clk,
    input  logic                  i_aresetn,
    input  logic [DATA_WIDTH-1:0] i_pixel,
    input  logic                  i_data_valid,
    input  logic                  i_start_of_frame,
    output logic [DATA_WIDTH-1:0] o_image_kernel_buffer [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1],
    output logic                  o_data_valid,
    output logic                  o_start_of_frame
);

    localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] EDGE_COL = COL_W'(KERNEL_SIZE - 1);
    localparam logic [ROW_W-1:0] EDGE_ROW = ROW_W'(KERNEL_SIZE - 1);

    localparam logic [0:0] ST_WAIT_SOF = 1'b0;
    localparam logic [0:0] ST_ACTIVE   = 1'b1;

    logic [0:0]            r_state;
    logic [COL_W-1:0]      r_col;
    logic [ROW_W-1:0]      r_row;
    logic                  r_valid;
    logic                  r_sof;
    logic [DATA_WIDTH-1:0] r_win      [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1];
    logic [DATA_WIDTH-1:0] r_line_buf [0:KERNEL_SIZE-2][0:IMG_WIDTH-1];

    logic                  w_sof;
    logic                  w_accept;
    logic [COL_W-1:0]      w_col;
    logic [ROW_W-1:0]      w_row;
    logic                  w_emit;
    logic                  w_first;
    logic                  w_last_col;
    logic                  w_last_pix;

    // An SOF pixel always restarts the frame at (0,0), whatever the state.
    assign w_sof      = i_data_valid && i_start_of_frame;
    assign w_accept   = w_sof || (i_data_valid && (r_state == ST_ACTIVE));
    assign w_col      = w_sof ? '0 : r_col;
    assign w_row      = w_sof ? '0 : r_row;
    assign w_emit     = (w_row >= EDGE_ROW) && (w_col >= EDGE_COL);
    assign w_first    = (w_row == EDGE_ROW) && (w_col == EDGE_COL);
    assign w_last_col = (w_col == LAST_COL);
    assign w_last_pix = w_last_col && (w_row == LAST_ROW);

    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            r_state <= ST_WAIT_SOF;
            r_col   <= '0;
            r_row   <= '0;
            r_valid <= 1'b0;
            r_sof   <= 1'b0;
            for (int r = 0; r < KERNEL_SIZE; r++) begin
                for (int c = 0; c < KERNEL_SIZE; c++) begin
                    r_win[r][c] <= '0;
                end
            end
        end else begin
            r_valid <= w_accept && w_emit;
            r_sof   <= w_accept && w_emit && w_first;
            if (w_accept) begin
                for (int r = 0; r < KERNEL_SIZE; r++) begin
                    for (int c = 0; c < KERNEL_SIZE - 1; c++) begin
                        r_win[r][c] <= r_win[r][c+1];
                    end
                end
                r_win[KERNEL_SIZE-1][KERNEL_SIZE-1] <= i_pixel;
                // Line buffer k holds the line k+1 above the incoming pixel.
                for (int k = 0; k < KERNEL_SIZE - 1; k++) begin
                    r_win[KERNEL_SIZE-2-k][KERNEL_SIZE-1] <= r_line_buf[k][w_col];
                end

                if (w_last_pix) begin
                    r_col   <= '0;
                    r_row   <= '0;
                    r_state <= ST_WAIT_SOF;
                end else if (w_last_col) begin
                    r_col   <= '0;
                    r_row   <= w_row + ROW_W'(1);
                    r_state <= ST_ACTIVE;
                end else begin
                    r_col   <= w_col + COL_W'(1);
                    r_row   <= w_row;
                    r_state <= ST_ACTIVE;
                end
            end
        end
    end

    // Line buffer contents are don't-care after reset, so they carry no reset.
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_line_buf[0][w_col] <= i_pixel;
            for (int k = 0; k < KERNEL_SIZE - 2; k++) begin
                r_line_buf[k+1][w_col] <= r_line_buf[k][w_col];
            end
        end
    end

    assign o_image_kernel_buffer = r_win;
    assign o_data_valid          = r_valid;
    assign o_start_of_frame      = r_sof;

endmodule

// File: tb/tb_image_kernel_window.sv
// Directed bench for image_kernel_window on an 8x6 frame with a 5x5 kernel.
// Expected windows are built from the pixel formula and queued per frame.
module tb_image_kernel_window;

    localparam int DW = 8;
    localparam int K  = 5;
    localparam int IW = 8;
    localparam int IH = 6;
    localparam int FW = DW * K * K;

    logic          clk;
    logic          aresetn;
    logic [DW-1:0] pixel;
    logic          dvalid;
    logic          sof;
    logic [DW-1:0] o_buf [0:K-1][0:K-1];
    logic          o_dvalid;
    logic          o_sof;

    logic [FW:0]   exp_q[$];
    int            n_checks;
    int            n_errors;

    image_kernel_window #(
        .DATA_WIDTH (DW),
        .KERNEL_SIZE(K),
        .IMG_WIDTH  (IW),
        .IMG_HEIGHT (IH)
    ) dut (
        .i_clk                (clk),
        .i_aresetn            (aresetn),
        .i_pixel              (pixel),
        .i_data_valid         (dvalid),
        .i_start_of_frame     (sof),
        .o_image_kernel_buffer(o_buf),
        .o_data_valid         (o_dvalid),
        .o_start_of_frame     (o_sof)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] pix(input bit inv, input int r, input int c);
        logic [DW-1:0] v;
        v = DW'(r * 16 + c);
        return inv ? (8'd255 - v) : v;
    endfunction

    // Window emitted for the pixel at (row, col): top-left is (row-K+1, col-K+1).
    function automatic logic [FW-1:0] win_exp(input bit inv, input int row, input int col);
        logic [FW-1:0] f;
        f = '0;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                f[(r*K+c)*DW +: DW] = pix(inv, row - K + 1 + r, col - K + 1 + c);
        return f;
    endfunction

    function automatic logic [FW-1:0] flat_obs();
        logic [FW-1:0] f;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                f[(r*K+c)*DW +: DW] = o_buf[r][c];
        return f;
    endfunction

    task automatic drive(input logic v, input logic s, input logic [DW-1:0] p);
        @(negedge clk);
        dvalid = v;
        sof    = s;
        pixel  = p;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00);
    endtask

    // Drives n pixels of a frame starting at (0,0); full frames queue their windows.
    task automatic send_pixels(input bit inv, input int n, input bit with_sof, input bit bubbles);
        if (n == IW * IH) begin
            for (int r = K - 1; r < IH; r++)
                for (int c = K - 1; c < IW; c++)
                    exp_q.push_back({(r == K - 1 && c == K - 1), win_exp(inv, r, c)});
        end
        for (int i = 0; i < n; i++) begin
            if (bubbles) idle($urandom_range(0, 1) * $urandom_range(1, 3));
            drive(1'b1, with_sof && (i == 0), pix(inv, i / IW, i % IW));
        end
    endtask

    // Output monitor: pops one expected window per o_data_valid pulse.
    always begin
        logic           in_v;
        logic [FW:0]    e;
        @(posedge clk);
        in_v = dvalid;
        #1;
        if (!in_v) check("idle_valid", {255'd0, o_dvalid}, 256'd0);
        if (!o_dvalid) begin
            if (o_sof) check("sof_without_valid", {255'd0, o_sof}, 256'd0);
        end else if (exp_q.size() == 0) begin
            check("extra_window", 256'd1, 256'd0);
        end else begin
            e = exp_q.pop_front();
            check("win", {56'd0, flat_obs()}, {56'd0, e[FW-1:0]});
            check("sof", {255'd0, o_sof}, {255'd0, e[FW]});
        end
    end

    task automatic drain(input string tag);
        idle(4);
        check(tag, 256'(exp_q.size()), 256'd0);
        exp_q.delete();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        aresetn  = 1'b0;
        dvalid   = 1'b0;
        sof      = 1'b0;
        pixel    = '0;
        #12;
        check("reset_win", {56'd0, flat_obs()}, 256'd0);
        check("reset_dv", {255'd0, o_dvalid}, 256'd0);
        check("reset_sof", {255'd0, o_sof}, 256'd0);
        @(negedge clk);
        aresetn = 1'b1;
        idle(2);

        // Full frame, continuous valid, then window hold while idle.
        send_pixels(1'b0, IW * IH, 1'b1, 1'b0);
        idle(3);
        check("hold", {56'd0, flat_obs()}, {56'd0, win_exp(1'b0, IH - 1, IW - 1)});
        drain("full_frame_count");

        // Same frame with random bubbles.
        send_pixels(1'b0, IW * IH, 1'b1, 1'b1);
        drain("bubble_count");

        // Pixels without SOF are ignored, before and after a frame.
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, 8'(i + 100));
        send_pixels(1'b0, IW * IH, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 8'(i + 50));
        drain("no_sof_count");

        // Abandoned frame after 30 pixels, then a fresh frame.
        send_pixels(1'b1, 30, 1'b1, 1'b0);
        send_pixels(1'b0, IW * IH, 1'b1, 1'b0);
        drain("sof_mid_count");

        // Asynchronous reset while the window holds data.
        send_pixels(1'b0, 36, 1'b1, 1'b0);
        idle(1);
        check("win_nonzero", {255'd0, (flat_obs() != '0)}, 256'd1);
        #2;
        aresetn = 1'b0;
        #1;
        check("rst_mid_win", {56'd0, flat_obs()}, 256'd0);
        check("rst_mid_dv", {255'd0, o_dvalid}, 256'd0);
        check("rst_mid_sof", {255'd0, o_sof}, 256'd0);
        idle(2);
        aresetn = 1'b1;
        for (int i = 0; i < 12; i++) drive(1'b1, 1'b0, 8'(i + 7));
        send_pixels(1'b0, IW * IH, 1'b1, 1'b0);
        drain("after_reset_count");

        // Back-to-back frames, second one inverted.
        send_pixels(1'b0, IW * IH, 1'b1, 1'b0);
        send_pixels(1'b1, IW * IH, 1'b1, 1'b0);
        drain("b2b_count");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
